bank_arbiter: RTL and testbench

//  Round-robin request arbiter sitting directly upstream of one memory bank.

---
 rtl/bank_arbiter.sv | 137 +++++++++++++
 tb/tb_bank_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_arbiter.sv
// Round-robin arbiter feeding one memory bank; returns read data to the issuing port.
// Latency: command on bank pins 1 cycle after accept, read response READ_LAT cycles later.
// Backpressure: one-hot req_ready grant; optional conflict counter under BANK_ARB_STATS_EN.
module bank_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_data_in,
  output logic                        bank_read_enable,
  output logic                        bank_write_enable,
  input  logic [DATA_W-1:0]           bank_data_out,
  input  logic                        bank_valid_out
`ifdef BANK_ARB_STATS_EN
  ,
  output logic [15:0]                 conflict_cnt
`endif
);

  localparam int            PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW:0]   NP   = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] id;
  } tag_t;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_id;
  logic [PW-1:0] cmd_id;
  logic [PW:0]   idx;
  logic          found;
  cmd_t          sel;
  tag_t          tag_q [READ_LAT];
  tag_t          tag_out;

  // Search upward from rr_ptr with wrap; idx never exceeds 2*NUM_PORTS-2.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= NP) idx = idx - NP;
      if (!found && req_valid[idx[PW-1:0]]) begin
        found    = 1'b1;
        grant_id = idx[PW-1:0];
      end
    end
    if (found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == PW'(i)) begin
        sel.we   = req_we[i];
        sel.addr = req_addr[i*ADDR_W +: ADDR_W];
        sel.data = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr            <= '0;
      cmd_id            <= '0;
      bank_addr         <= '0;
      bank_data_in      <= '0;
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
    end else begin
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
      if (found) begin
        bank_addr         <= sel.addr;
        bank_data_in      <= sel.data;
        bank_read_enable  <= ~sel.we;
        bank_write_enable <= sel.we;
        cmd_id            <= grant_id;
        rr_ptr            <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Tag enters alongside the read_enable the bank samples, so it lines up with valid_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < READ_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{vld: bank_read_enable, id: cmd_id};
      for (int k = 1; k < READ_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[READ_LAT-1];

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      resp_valid[i] = bank_valid_out & tag_out.vld & (tag_out.id == PW'(i));
  end

  assign resp_data = bank_data_out;

`ifdef BANK_ARB_STATS_EN
  logic multi_req;
  assign multi_req = (req_valid & (req_valid - NUM_PORTS'(1))) != '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if (multi_req && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter with a one-cycle-latency bank model and a read-response scoreboard.
module tb_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_we = '0;
  logic [7:0]  a [4];
  logic [7:0]  d [4];
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_ready, resp_valid;
  logic [7:0]  resp_data, bank_addr, bank_data_in, bank_data_out;
  logic        bank_read_enable, bank_write_enable, bank_valid_out;
  logic        bank_vo_q = 1'b0;
  logic        spur = 1'b0;
  logic [7:0]  mem [256];
  bit          wr_seen [256];
  logic [7:0]  ref_mem [256];
`ifdef BANK_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  typedef struct { logic [3:0] port; logic [7:0] data; } sb_t;
  sb_t sbq [$];

  typedef struct { logic [3:0] v; logic [3:0] we; logic [3:0] rdy; } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  assign req_addr  = {a[3], a[2], a[1], a[0]};
  assign req_wdata = {d[3], d[2], d[1], d[0]};
  assign bank_valid_out = bank_vo_q | spur;

  // Bank: unwritten locations read as addr ^ 8'h5A.
  always @(posedge clk) begin
    if (bank_write_enable) begin
      mem[bank_addr]     <= bank_data_in;
      wr_seen[bank_addr] <= 1'b1;
    end
    bank_vo_q <= bank_read_enable;
    if (bank_read_enable)
      bank_data_out <= wr_seen[bank_addr] ? mem[bank_addr] : (bank_addr ^ 8'h5A);
  end

  bank_arbiter #(.NUM_PORTS(4), .ADDR_W(8), .DATA_W(8), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .bank_addr(bank_addr), .bank_data_in(bank_data_in),
    .bank_read_enable(bank_read_enable), .bank_write_enable(bank_write_enable),
    .bank_data_out(bank_data_out), .bank_valid_out(bank_valid_out)
`ifdef BANK_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1; drives one cycle and checks grant plus resulting bank command.
  task automatic step(input logic [3:0] v, input logic [3:0] we, input logic [3:0] rdy);
    int   p;
    sb_t  e;
    logic exp_re, exp_we;
    req_valid = v;
    req_we    = we;
    #1;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    p = -1;
    for (int i = 0; i < 4; i++) if (rdy[i]) p = i;
    exp_re = (p >= 0) ? ~we[p] : 1'b0;
    exp_we = (p >= 0) ? we[p] : 1'b0;
    if (p >= 0) begin
      if (we[p]) ref_mem[a[p]] = d[p];
      else begin
        e.port = 4'(1 << p);
        e.data = ref_mem[a[p]];
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    chk("bank_read_enable", 32'(bank_read_enable), 32'(exp_re));
    chk("bank_write_enable", 32'(bank_write_enable), 32'(exp_we));
    if (p >= 0) chk("bank_addr", 32'(bank_addr), 32'(a[p]));
    if (exp_we) chk("bank_data_in", 32'(bank_data_in), 32'(d[p]));
  endtask

  task automatic rst();
    reset = 1'b1;
    req_valid = '0;
    req_we = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 4'b0000);
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (!reset && resp_valid != '0) begin
      if (sbq.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
      else begin
        e = sbq.pop_front();
        chk("resp_port", 32'(resp_valid), 32'(e.port));
        chk("resp_data", 32'(resp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq3 [6];
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 4; i++) begin
      a[i] = 8'h10 + 8'(i);
      d[i] = 8'hA0 + 8'(i);
    end
    // rr_ptr walks 0->1->2->1->0->2->3->1->1->3 across these rows.
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1111, 4'b0000, 4'b0001};
    tbl[2] = '{4'b1111, 4'b1111, 4'b0010};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0001};
    tbl[4] = '{4'b1000, 4'b1000, 4'b1000};
    tbl[5] = '{4'b0110, 4'b0100, 4'b0010};
    tbl[6] = '{4'b0110, 4'b0100, 4'b0100};
    tbl[7] = '{4'b0011, 4'b0000, 4'b0001};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[9] = '{4'b0100, 4'b0000, 4'b0100};

    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_bank_addr", 32'(bank_addr), 32'd0);
    chk("rst_bank_data_in", 32'(bank_data_in), 32'd0);
    chk("rst_read_enable", 32'(bank_read_enable), 32'd0);
    chk("rst_write_enable", 32'(bank_write_enable), 32'd0);
`ifdef BANK_ARB_STATS_EN
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step(tbl[i].v, tbl[i].we, tbl[i].rdy);
    idle(3);

    // Write then read of the same address from port 1, with latency checks
    a[1] = 8'd9; d[1] = 8'd24;
    step(4'b0010, 4'b0010, 4'b0010);
    step(4'b0010, 4'b0000, 4'b0010);
    chk("t2_resp_early", 32'(resp_valid), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    chk("t2_resp_valid", 32'(resp_valid), 32'b0010);
    chk("t2_resp_data", 32'(resp_data), 32'd24);
    idle(2);

    // Three persistent readers rotate 0,2,3
    rst();
    for (int i = 0; i < 4; i++) a[i] = 8'h20 + 8'(i);
    seq3[0] = 4'b0001; seq3[1] = 4'b0100; seq3[2] = 4'b1000;
    seq3[3] = 4'b0001; seq3[4] = 4'b0100; seq3[5] = 4'b1000;
    for (int i = 0; i < 6; i++) step(4'b1101, 4'b0000, seq3[i]);
    idle(3);

    // Cross-port write then read at the top address
    a[3] = 8'd255; d[3] = 8'd145;
    step(4'b1000, 4'b1000, 4'b1000);
    a[0] = 8'd255;
    step(4'b0001, 4'b0000, 4'b0001);
    idle(3);

    // Reset during an in-flight read drops it; stray valid_out is ignored
    a[2] = 8'h33;
    step(4'b0100, 4'b0000, 4'b0100);
    void'(sbq.pop_back());
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("t5_read_enable_cleared", 32'(bank_read_enable), 32'd0);
    chk("t5_resp_in_reset", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    spur = 1'b1;
    #1;
    chk("t5_spurious_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    spur = 1'b0;
    step(4'b0100, 4'b0000, 4'b0100);
    idle(3);

`ifdef BANK_ARB_STATS_EN
    rst();
    chk("t6_cnt_after_reset", 32'(conflict_cnt), 32'd0);
    for (int i = 0; i < 4; i++) a[i] = 8'hF0 + 8'(i);
    for (int i = 0; i < 10; i++)
      step(4'b0011, 4'b0011, (i % 2 == 0) ? 4'b0001 : 4'b0010);
    for (int i = 0; i < 5; i++) step(4'b0100, 4'b0100, 4'b0100);
    chk("t6_conflict_cnt", 32'(conflict_cnt), 32'd10);
    idle(2);
`endif

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
